// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester arbiter sharing one combinational ALU behind registered operands.
// Define ALU_ARB_RR_EN for round-robin tie-breaking; default is fixed priority (req0 wins).
module alu_arbiter #(
    parameter int DW     = 4,
    parameter int SW     = 3,
    parameter int SETTLE = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic [SW-1:0] s0,
    input  logic [DW-1:0] a0,
    input  logic [DW-1:0] b0,
    input  logic          cin0,
    output logic          gnt0,
    output logic          done0,
    input  logic          req1,
    input  logic [SW-1:0] s1,
    input  logic [DW-1:0] a1,
    input  logic [DW-1:0] b1,
    input  logic          cin1,
    output logic          gnt1,
    output logic          done1,
    output logic [SW-1:0] alu_s,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic          alu_cin,
    input  logic [DW-1:0] alu_y,
    output logic [DW-1:0] y_out,
    output logic          busy
);
    localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
    state_t state, state_next;
    logic [CW-1:0] cnt;
    logic win1, owner, settled, start;
`ifdef ALU_ARB_RR_EN
    // rr names the requester preferred on a tie; it flips away from each winner
    logic rr;
    assign win1 = req1 & (~req0 | rr);
    always_ff @(posedge clk or posedge rst)
        if (rst) rr <= 1'b0;
        else if (start) rr <= ~win1;
`else
    assign win1 = req1 & ~req0;
`endif
    assign start   = (state == IDLE) & (req0 | req1);
    assign settled = cnt == CW'(SETTLE - 1);
    assign busy    = state != IDLE;
    always_comb begin
        state_next = IDLE;
        if (state == IDLE) state_next = start ? ISSUE : IDLE;
        else if (state == ISSUE) state_next = settled ? DONE : ISSUE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            owner   <= 1'b0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            alu_s   <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_cin <= 1'b0;
            y_out   <= '0;
        end else begin
            state <= state_next;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            if (start) begin
                owner   <= win1;
                gnt0    <= ~win1;
                gnt1    <= win1;
                alu_s   <= win1 ? s1 : s0;
                alu_a   <= win1 ? a1 : a0;
                alu_b   <= win1 ? b1 : b0;
                alu_cin <= win1 ? cin1 : cin0;
                cnt     <= '0;
            end
            if (state == ISSUE) begin
                cnt <= cnt + 1'b1;
                if (settled) begin
                    y_out <= alu_y;
                    done0 <= ~owner;
                    done1 <= owner;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter with a behavioural ALU on alu_*.
module tb_alu_arbiter;
    logic clk = 1'b0, rst = 1'b1;
    logic req0 = 0, req1 = 0, cin0 = 0, cin1 = 0;
    logic [2:0] s0 = 0, s1 = 0, alu_s;
    logic [3:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0, alu_a, alu_b, alu_y, y_out;
    logic gnt0, gnt1, done0, done1, alu_cin, busy;
    int checks = 0, errors = 0, cyc = 0, last_done;
    logic [3:0] sweep_y [8] = '{4'hE, 4'h8, 4'h2, 4'hB, 4'h9, 4'hC, 4'h7, 4'hA};
    logic [1:0] tie_gnt [4];

    alu_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .s0(s0), .a0(a0), .b0(b0), .cin0(cin0), .gnt0(gnt0), .done0(done0),
        .req1(req1), .s1(s1), .a1(a1), .b1(b1), .cin1(cin1), .gnt1(gnt1), .done1(done1),
        .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_y(alu_y),
        .y_out(y_out), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [3:0] alu_model(logic [2:0] s, logic [3:0] a, logic [3:0] b, logic c);
        case (s)
            3'd0: return a + b + {3'b0, c};
            3'd1: return a - b - {3'b0, c};
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ~a;
            3'd6: return {a[2:0], c};
            default: return b;
        endcase
    endfunction

    always_comb alu_y = alu_model(alu_s, alu_a, alu_b, alu_cin);

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef ALU_ARB_RR_EN
        tie_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        tie_gnt = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        tick();
        tick();
        check("reset_outs", {gnt0, gnt1, done0, done1, busy, alu_cin, alu_s, alu_a, alu_b}, 16'h0);
        check("reset_y", y_out, 0);
        rst = 1'b0;
        tick();
        check("idle_after_reset", {gnt0, gnt1, done0, done1, busy}, 0);

        // single op from requester 0
        req0 = 1; s0 = 3'd2; a0 = 4'h3; b0 = 4'hA; cin0 = 1;
        tick();
        check("single_gnt", {busy, gnt1, gnt0}, 3'b101);
        check("single_alu", {alu_cin, alu_s, alu_a, alu_b}, {1'b1, 3'd2, 4'h3, 4'hA});
        req0 = 0;
        tick();
        check("single_done", {gnt0, gnt1, done1, done0}, 4'b0001);
        check("single_y", y_out, 4'h2);
        tick();
        check("single_end", {busy, done0, done1, gnt1}, 0);

        // back-to-back sweep on requester 1
        a1 = 4'h3; b1 = 4'hA; cin1 = 1;
        for (int i = 0; i < 8; i++) begin
            s1 = 3'(i); req1 = 1;
            tick();
            check("sweep_gnt", {gnt0, gnt1}, 2'b01);
            req1 = 0;
            tick();
            check("sweep_done", {done0, done1}, 2'b01);
            check("sweep_y", y_out, sweep_y[i]);
            if (i > 0) check("sweep_spacing", 16'(cyc - last_done), 3);
            last_done = cyc;
            tick();
        end

        // tie held for four operations
        req0 = 1; req1 = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("tie_gnt", {gnt1, gnt0}, tie_gnt[i]);
            tick();
            tick();
        end
        req0 = 0; req1 = 0;
        tick();
        tick();
        tick();
        check("tie_idle", busy, 0);

        // requests ignored while busy; operand change after grant ignored
        req0 = 1; s0 = 3'd0; a0 = 4'h5; b0 = 4'h6; cin0 = 0;
        tick();
        check("busy_gnt0", {gnt1, gnt0}, 2'b01);
        req0 = 0; a0 = 4'hF;
        req1 = 1; s1 = 3'd4; a1 = 4'h9; b1 = 4'h3; cin1 = 0;
        tick();
        check("busy_done0", {gnt1, done0}, 2'b01);
        check("busy_y0", y_out, 4'hB);
        tick();
        check("busy_nogrant", {gnt1, done0}, 0);
        tick();
        check("busy_gnt1", {gnt0, gnt1, alu_a}, {2'b01, 4'h9});
        req1 = 0;
        tick();
        check("busy_y1", {done0, done1, y_out}, {2'b01, 4'hA});
        tick();

        // asynchronous reset while the op is in ISSUE
        req0 = 1; s0 = 3'd1; a0 = 4'h7; b0 = 4'h2; cin0 = 0;
        tick();
        check("rst_gnt0", gnt0, 1);
        req0 = 0;
        #2 rst = 1;
        #1 check("rst_async", {gnt0, gnt1, done0, done1, busy, alu_cin, alu_s, alu_a, alu_b}, 0);
        check("rst_async_y", y_out, 0);
        tick();
        check("rst_no_done", {done0, y_out}, 0);
        rst = 0;
        tick();
        check("rst_idle", {busy, done0}, 0);
        req0 = 1;
        tick();
        check("post_rst_gnt", gnt0, 1);
        req0 = 0;
        tick();
        check("post_rst_done", {done0, y_out}, {1'b1, 4'h5});
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
